// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the dcache memory master and the L1 arbiter.
// Writes are acked on enqueue and drained in order; reads pass only when the buffer is empty.
module dcache_write_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          COALESCE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_request,
  input  logic [29:0] up_addr,
  input  logic        up_rnw,
  input  logic [4:0]  up_rlen,
  input  logic [31:0] up_wdata,
  input  logic [3:0]  up_wbe,
  output logic        up_ack,
  output logic        up_rvalid,
  output logic [31:0] up_rdata,
  output logic        up_write_outstanding,
  output logic        dn_request,
  output logic [29:0] dn_addr,
  output logic        dn_rnw,
  output logic [4:0]  dn_rlen,
  output logic [31:0] dn_wdata,
  output logic [3:0]  dn_wbe,
  input  logic        dn_ack,
  input  logic        dn_rvalid,
  input  logic [31:0] dn_rdata,
  input  logic        dn_write_outstanding
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;
  typedef enum logic [0:0] {StIdle, StReadWait} state_e;

  logic [29:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  wbe_q  [DEPTH];

  ptr_t       head_q, tail_q, last;
  cnt_t       count_q;
  state_e     state_q, state_d;
  logic [4:0] beat_q, beat_d;

  logic        full, empty, is_write, merge, write_acc, push, pop;
  logic [31:0] wmask;

  assign full      = (count_q == cnt_t'(DEPTH));
  assign empty     = (count_q == '0);
  assign last      = tail_q - ptr_t'(1);
  assign is_write  = up_request & ~up_rnw;
  // Only the youngest entry is a merge target, and never while it is also the head.
  assign merge     = COALESCE && (count_q >= cnt_t'(2)) && (addr_q[last] == up_addr);
  assign write_acc = is_write & (~full | merge);
  assign push      = write_acc & ~merge;
  assign pop       = (state_q == StIdle) & ~empty & dn_ack;

  assign wmask = {{8{up_wbe[3]}}, {8{up_wbe[2]}}, {8{up_wbe[1]}}, {8{up_wbe[0]}}};

  assign up_write_outstanding = ~empty | dn_write_outstanding;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    up_ack     = write_acc;
    up_rvalid  = 1'b0;
    up_rdata   = dn_rdata;
    dn_request = 1'b0;
    dn_addr    = addr_q[head_q];
    dn_rnw     = 1'b0;
    dn_rlen    = '0;
    dn_wdata   = data_q[head_q];
    dn_wbe     = wbe_q[head_q];
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          dn_request = 1'b1;
        end else if (up_request && up_rnw) begin
          dn_request = 1'b1;
          dn_addr    = up_addr;
          dn_rnw     = 1'b1;
          dn_rlen    = up_rlen;
          dn_wdata   = up_wdata;
          dn_wbe     = up_wbe;
          up_ack     = dn_ack;
          if (dn_ack) begin
            state_d = StReadWait;
            beat_d  = up_rlen;
          end
        end
      end
      StReadWait: begin
        up_rvalid = dn_rvalid;
        if (dn_rvalid) begin
          if (beat_q == '0) state_d = StIdle;
          else              beat_d  = beat_q - 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      head_q  <= head_q + ptr_t'(pop);
      tail_q  <= tail_q + ptr_t'(push);
      count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Disabled lanes are stored as zero so merged entries carry only written bytes.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= up_addr;
      data_q[tail_q] <= up_wdata & wmask;
      wbe_q[tail_q]  <= up_wbe;
    end else if (is_write && merge) begin
      for (int b = 0; b < 4; b++) begin
        if (up_wbe[b]) data_q[last][8*b +: 8] <= up_wdata[8*b +: 8];
      end
      wbe_q[last] <= wbe_q[last] | up_wbe;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: directed scenarios plus random traffic, all checked against
// a queue-based model of the posted-write buffer.
module tb_dcache_write_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam bit          COALESCE = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_request, up_rnw;
  logic [29:0] up_addr;
  logic [4:0]  up_rlen;
  logic [31:0] up_wdata;
  logic [3:0]  up_wbe;
  logic        up_ack, up_rvalid, up_write_outstanding;
  logic [31:0] up_rdata;
  logic        dn_request, dn_rnw;
  logic [29:0] dn_addr;
  logic [4:0]  dn_rlen;
  logic [31:0] dn_wdata;
  logic [3:0]  dn_wbe;
  logic        dn_ack, dn_rvalid, dn_write_outstanding;
  logic [31:0] dn_rdata;

  dcache_write_buffer #(.DEPTH(DEPTH), .COALESCE(COALESCE)) dut (
    .clk(clk), .rst(rst),
    .up_request(up_request), .up_addr(up_addr), .up_rnw(up_rnw), .up_rlen(up_rlen),
    .up_wdata(up_wdata), .up_wbe(up_wbe), .up_ack(up_ack), .up_rvalid(up_rvalid),
    .up_rdata(up_rdata), .up_write_outstanding(up_write_outstanding),
    .dn_request(dn_request), .dn_addr(dn_addr), .dn_rnw(dn_rnw), .dn_rlen(dn_rlen),
    .dn_wdata(dn_wdata), .dn_wbe(dn_wbe), .dn_ack(dn_ack), .dn_rvalid(dn_rvalid),
    .dn_rdata(dn_rdata), .dn_write_outstanding(dn_write_outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  wbe;
  } ent_t;

  ent_t q[$];
  bit   reading;
  int   beats_left;
  bit   chk_en;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        last_ack, last_dreq;
  logic [29:0] last_daddr;
  logic [31:0] last_dwdata;
  logic [3:0]  last_dwbe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] wbe);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{wbe[b]}};
    return m;
  endfunction

  // Inputs are set just after a falling edge; outputs are checked 1 time unit later and the
  // model advances on the rising edge.
  task automatic step();
    bit wr, mg, e_ack, e_dreq, e_rv;
    #1;
    wr     = up_request && !up_rnw;
    mg     = COALESCE && q.size() >= 2 && q[$].addr == up_addr;
    e_ack  = wr ? (mg || q.size() < DEPTH)
                : (up_request && !reading && q.size() == 0 && dn_ack);
    e_dreq = !reading && (q.size() != 0 || (up_request && up_rnw));
    e_rv   = reading && dn_rvalid;
    last_ack    = up_ack;
    last_dreq   = dn_request;
    last_daddr  = dn_addr;
    last_dwdata = dn_wdata;
    last_dwbe   = dn_wbe;
    if (chk_en) begin
      check_eq("up_ack", 32'(up_ack), 32'(e_ack));
      check_eq("dn_request", 32'(dn_request), 32'(e_dreq));
      if (e_dreq && q.size() != 0) begin
        check_eq("dn_addr_wr", 32'(dn_addr), 32'(q[0].addr));
        check_eq("dn_wdata", dn_wdata, q[0].data);
        check_eq("dn_wbe", 32'(dn_wbe), 32'(q[0].wbe));
        check_eq("dn_rnw_wr", 32'(dn_rnw), 32'(0));
        check_eq("dn_rlen_wr", 32'(dn_rlen), 32'(0));
      end else if (e_dreq) begin
        check_eq("dn_addr_rd", 32'(dn_addr), 32'(up_addr));
        check_eq("dn_rnw_rd", 32'(dn_rnw), 32'(1));
        check_eq("dn_rlen_rd", 32'(dn_rlen), 32'(up_rlen));
      end
      check_eq("up_rvalid", 32'(up_rvalid), 32'(e_rv));
      if (e_rv) check_eq("up_rdata", up_rdata, dn_rdata);
      check_eq("wr_outstanding", 32'(up_write_outstanding),
               32'(q.size() != 0 || dn_write_outstanding));
    end
    @(posedge clk);
    if (!rst) begin
      q.delete();
      reading    = 1'b0;
      beats_left = 0;
    end else begin
      bit pop, rd_go;
      pop   = !reading && q.size() != 0 && dn_ack;
      rd_go = !reading && q.size() == 0 && up_request && up_rnw && dn_ack;
      if (wr && mg) begin
        ent_t e = q[$];
        for (int b = 0; b < 4; b++) if (up_wbe[b]) e.data[8*b +: 8] = up_wdata[8*b +: 8];
        e.wbe = e.wbe | up_wbe;
        q[q.size()-1] = e;
      end
      if (pop) void'(q.pop_front());
      if (wr && !mg && e_ack) begin
        ent_t n;
        n.addr = up_addr;
        n.data = up_wdata & lane_mask(up_wbe);
        n.wbe  = up_wbe;
        q.push_back(n);
      end
      if (reading && dn_rvalid) begin
        beats_left--;
        if (beats_left == 0) reading = 1'b0;
      end
      if (rd_go) begin
        reading    = 1'b1;
        beats_left = int'(up_rlen) + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 1'b1; up_request = 1'b0; up_rnw = 1'b0; up_addr = '0; up_rlen = '0;
    up_wdata = '0; up_wbe = '0; dn_ack = 1'b0; dn_rvalid = 1'b0; dn_rdata = '0;
    dn_write_outstanding = 1'b0;
  endtask

  task automatic set_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    up_request = 1'b1; up_rnw = 1'b0; up_addr = a; up_wdata = d; up_wbe = be;
  endtask

  task automatic set_rd(input logic [29:0] a, input logic [4:0] len);
    up_request = 1'b1; up_rnw = 1'b1; up_addr = a; up_rlen = len;
  endtask

  initial begin
    chk_en = 1'b0;
    reading = 1'b0;
    beats_left = 0;
    @(negedge clk);
    quiet(); rst = 1'b0;
    step(); step();
    chk_en = 1'b1;
    quiet(); step();
    check_eq("reset_dn_request", 32'(last_dreq), 32'(0));

    // Single write through an empty buffer.
    quiet(); set_wr(30'h10, 32'hAABBCCDD, 4'hF); step();
    check_eq("t1_ack", 32'(last_ack), 32'(1));
    quiet(); step();
    check_eq("t1_dreq", 32'(last_dreq), 32'(1));
    check_eq("t1_daddr", 32'(last_daddr), 32'h10);
    quiet(); dn_ack = 1'b1; step();
    quiet(); dn_write_outstanding = 1'b1; step();
    quiet(); step();

    // Fill to DEPTH, fifth write stalls until one drain.
    for (int i = 0; i < 5; i++) begin
      quiet(); set_wr(30'h100 + 30'(i * 8), 32'h1000 + i, 4'hF); step();
    end
    check_eq("t2_5th_stall", 32'(last_ack), 32'(0));
    quiet(); set_wr(30'h120, 32'h1004, 4'hF); dn_ack = 1'b1; step();
    check_eq("t2_stall_on_pop", 32'(last_ack), 32'(0));
    quiet(); set_wr(30'h120, 32'h1004, 4'hF); step();
    check_eq("t2_5th_acked", 32'(last_ack), 32'(1));
    for (int i = 0; i < 5; i++) begin quiet(); dn_ack = 1'b1; step(); end

    // Coalescing into the youngest non-head entry.
    quiet(); set_wr(30'h20, 32'h11111111, 4'h1); step();
    quiet(); set_wr(30'h24, 32'h11111111, 4'h1); step();
    quiet(); set_wr(30'h24, 32'h22222200, 4'h2); step();
    quiet(); dn_ack = 1'b1; step();
    quiet(); dn_ack = 1'b1; step();
    check_eq("t3_merged_data", last_dwdata, 32'h00002211);
    check_eq("t3_merged_wbe", 32'(last_dwbe), 32'h3);
    quiet(); step();
    check_eq("t3_count2", 32'(last_dreq), 32'(0));

    // Read waits behind a buffered write, then a write is parked during READ_WAIT.
    quiet(); set_wr(30'h30, 32'h33333333, 4'hF); step();
    quiet(); set_rd(30'h200, 5'd3); dn_ack = 1'b1; step();
    check_eq("t4_read_blocked", 32'(last_ack), 32'(0));
    quiet(); set_rd(30'h200, 5'd3); dn_ack = 1'b1; step();
    check_eq("t4_read_acked", 32'(last_ack), 32'(1));
    for (int i = 0; i < 4; i++) begin
      quiet(); dn_rvalid = 1'b1; dn_rdata = 32'hD0 + i;
      if (i == 0) set_wr(30'h50, 32'h55555555, 4'hF);
      step();
      check_eq("t5_no_issue", 32'(last_dreq), 32'(0));
    end
    quiet(); step();
    check_eq("t5_issue_after", 32'(last_dreq), 32'(1));
    quiet(); dn_ack = 1'b1; step();

    // Reset in READ_WAIT with three buffered writes.
    quiet(); set_rd(30'h300, 5'd7); dn_ack = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      quiet(); set_wr(30'h60 + 30'(i * 8), 32'h6000 + i, 4'hF); step();
    end
    quiet(); rst = 1'b0; step();
    quiet(); dn_rvalid = 1'b1; dn_rdata = 32'hDEAD; step();
    check_eq("t6_dreq", 32'(last_dreq), 32'(0));

    // Random traffic on a small address set to provoke merges and stalls.
    for (int n = 0; n < 4000; n++) begin
      quiet();
      rst        = ($urandom_range(0, 199) != 0);
      up_request = ($urandom_range(0, 3) != 0);
      up_rnw     = ($urandom_range(0, 4) == 0);
      up_addr    = 30'h40 + 30'($urandom_range(0, 3));
      up_rlen    = 5'($urandom_range(0, 3));
      up_wdata   = $urandom;
      up_wbe     = 4'($urandom_range(0, 15));
      dn_ack     = ($urandom_range(0, 2) == 0);
      dn_rvalid  = ($urandom_range(0, 1) == 0);
      dn_rdata   = $urandom;
      dn_write_outstanding = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
